// File: rtl/rx_addr_filter.sv
// rx_addr_filter
//   Destination-MAC filter on the receive byte stream. Follows preamble/SFD,
//   compares the six destination bytes against a station-address table and
//   issues one accept/reject verdict per frame.
// Ports
//   clk, rst            receive byte clock, synchronous active-high reset
//   rxdv, rxer, rxd     receive byte stream (preamble, SFD, frame)
//   promisc, allmulti   accept-all / accept-all-multicast modes
//   tbl_we/idx/byte/data  byte-wise table write port (dropped while tbl_busy)
//   tbl_en              per-entry enable, captured at SFD
//   tbl_busy            high while destination bytes are being compared
//   vld, accept, match_idx, bcast, mcast   verdict strobe and held result
//   abort               one-cycle strobe when rxdv drops inside the address
module rx_addr_filter #(
    parameter int NADDR = 14,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxdv,
    input  logic             rxer,
    input  logic [7:0]       rxd,
    input  logic             promisc,
    input  logic             allmulti,
    input  logic             tbl_we,
    input  logic [IDXW-1:0]  tbl_idx,
    input  logic [2:0]       tbl_byte,
    input  logic [7:0]       tbl_data,
    input  logic [NADDR-1:0] tbl_en,
    output logic             tbl_busy,
    output logic             vld,
    output logic             accept,
    output logic [IDXW-1:0]  match_idx,
    output logic             bcast,
    output logic             mcast,
    output logic             abort
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DEST, S_DONE, S_DRAIN} state_t;

    state_t state_q, state_d;

    // Station table: entry j, byte i (byte 0 is first on the wire). Not reset.
    logic [5:0][7:0] tbl_q [NADDR];

    logic [NADDR-1:0] m_q, m_d, eq;
    logic [2:0]       cnt_q;
    logic             bc_q, bc_d;
    logic             mc_q, mc_d;
    logic             err_q, err_d;

    logic             vld_q, accept_q, bcast_q, mcast_q, abort_q;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic             enter_dest;  // SFD accepted this cycle
    logic             take;        // a destination byte is sampled this cycle
    logic             verdict;     // the sampled byte is byte 5
    logic             do_abort;

    // Next-state and per-cycle control
    always_comb begin
        state_d    = state_q;
        enter_dest = 1'b0;
        take       = 1'b0;
        do_abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxdv) begin
                    if (rxd == 8'h55) begin
                        state_d = S_PRE;
                    end else if (rxd == 8'hD5) begin
                        state_d    = S_DEST;
                        enter_dest = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (!rxdv) begin
                    state_d = S_IDLE;
                end else if (rxd == 8'hD5) begin
                    state_d    = S_DEST;
                    enter_dest = 1'b1;
                end else if (rxd != 8'h55) begin
                    state_d = S_DRAIN;
                end
            end
            S_DEST: begin
                if (!rxdv) begin
                    state_d  = S_IDLE;
                    do_abort = 1'b1;
                end else begin
                    take = 1'b1;
                    if (cnt_q == 3'd5) state_d = S_DONE;
                end
            end
            S_DONE, S_DRAIN: begin
                if (!rxdv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign verdict = take && (cnt_q == 3'd5);

    // Compare result including the byte currently on the bus, so the verdict
    // can be registered on the same edge that samples byte 5.
    always_comb begin
        for (int j = 0; j < NADDR; j++) begin
            eq[j] = (tbl_q[j][cnt_q] == rxd);
        end
        m_d   = m_q & eq;
        bc_d  = bc_q & (rxd == 8'hFF);
        mc_d  = (cnt_q == 3'd0) ? rxd[0] : mc_q;
        err_d = err_q | rxer;
        // Downward scan: the last hit written is the lowest index
        idx_d = '1;
        for (int j = NADDR - 1; j >= 0; j--) begin
            if (m_d[j]) idx_d = IDXW'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            cnt_q    <= '0;
            bc_q     <= 1'b0;
            mc_q     <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            abort_q  <= 1'b0;
            accept_q <= 1'b0;
            bcast_q  <= 1'b0;
            mcast_q  <= 1'b0;
            idx_q    <= '1;
        end else begin
            state_q <= state_d;
            vld_q   <= verdict;
            abort_q <= do_abort;
            if (enter_dest) begin
                m_q   <= tbl_en;
                cnt_q <= '0;
                bc_q  <= 1'b1;
                mc_q  <= 1'b0;
                err_q <= rxer;  // error on the SFD byte counts
            end else if (take) begin
                m_q   <= m_d;
                bc_q  <= bc_d;
                mc_q  <= mc_d;
                err_q <= err_d;
                cnt_q <= cnt_q + 3'd1;
            end
            if (verdict) begin
                accept_q <= ~err_d & (promisc | bc_d | (mc_d & allmulti) | (|m_d));
                idx_q    <= idx_d;
                bcast_q  <= bc_d;
                mcast_q  <= mc_d;
            end else if (do_abort) begin
                accept_q <= 1'b0;
                idx_q    <= '1;
                bcast_q  <= 1'b0;
                mcast_q  <= 1'b0;
            end
        end
    end

    // Table writes are blocked while the compare is reading the table
    always_ff @(posedge clk) begin
        if (tbl_we && (state_q != S_DEST) && (tbl_idx < IDXW'(NADDR)) && (tbl_byte <= 3'd5)) begin
            tbl_q[tbl_idx][tbl_byte] <= tbl_data;
        end
    end

    assign tbl_busy  = (state_q == S_DEST);
    assign vld       = vld_q;
    assign accept    = accept_q;
    assign match_idx = idx_q;
    assign bcast     = bcast_q;
    assign mcast     = mcast_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_rx_addr_filter.sv
// Testbench for rx_addr_filter: table-driven frames plus hand-written
// sequences for abort, busy-drop of table writes and mid-frame reset.
module tb_rx_addr_filter;

    localparam int NADDR = 14;
    localparam int IDXW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rxdv, rxer;
    logic [7:0]       rxd;
    logic             promisc, allmulti;
    logic             tbl_we;
    logic [IDXW-1:0]  tbl_idx;
    logic [2:0]       tbl_byte;
    logic [7:0]       tbl_data;
    logic [NADDR-1:0] tbl_en;
    logic             tbl_busy, vld, accept, bcast, mcast, abort;
    logic [IDXW-1:0]  match_idx;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    rx_addr_filter #(.NADDR(NADDR), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .rxdv(rxdv), .rxer(rxer), .rxd(rxd),
        .promisc(promisc), .allmulti(allmulti),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_byte(tbl_byte), .tbl_data(tbl_data),
        .tbl_en(tbl_en), .tbl_busy(tbl_busy), .vld(vld), .accept(accept),
        .match_idx(match_idx), .bcast(bcast), .mcast(mcast), .abort(abort)
    );

    typedef struct {
        logic [47:0] da;      // byte 0 in [47:40]
        int          npre;    // number of 8'h55 before SFD
        int          errpos;  // dest byte with rxer=1, -1 none
        logic [13:0] en;
        logic        pr;
        logic        am;
        logic        acc;
        logic [3:0]  idx;
        logic        bc;
        logic        mc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Inputs change on the falling edge; return one cycle later so outputs
    // reflect the rising edge that sampled them.
    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        rxdv = dv; rxd = d; rxer = er;
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input int b, input logic [7:0] d);
        tbl_we = 1'b1; tbl_idx = IDXW'(idx); tbl_byte = 3'(b); tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic load(input int idx, input logic [47:0] a);
        for (int k = 0; k < 6; k++) wr(idx, k, a[47-8*k -: 8]);
    endtask

    task automatic preamble(input int npre);
        for (int k = 0; k < npre; k++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
    endtask

    task automatic send(input vec_t v, input string tag);
        logic early;
        early = 1'b0;
        tbl_en = v.en; promisc = v.pr; allmulti = v.am;
        for (int k = 0; k < v.npre; k++) begin
            drive(1'b1, 8'h55, 1'b0);
            early |= vld | abort;
        end
        drive(1'b1, 8'hD5, 1'b0);
        early |= vld | abort;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, v.da[47-8*k -: 8], (v.errpos == k));
            if (k < 5) early |= vld | abort;
        end
        chk({tag, " no early strobe"}, 32'(early), 32'd0);
        chk({tag, " vld"}, 32'(vld), 32'd1);
        chk({tag, " accept"}, 32'(accept), 32'(v.acc));
        chk({tag, " match_idx"}, 32'(match_idx), 32'(v.idx));
        chk({tag, " bcast"}, 32'(bcast), 32'(v.bc));
        chk({tag, " mcast"}, 32'(mcast), 32'(v.mc));
        drive(1'b1, 8'hAA, 1'b0);
        chk({tag, " vld one cycle"}, 32'(vld), 32'd0);
        chk({tag, " accept held"}, 32'(accept), 32'(v.acc));
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        promisc = 1'b0; allmulti = 1'b0;
    endtask

    localparam logic [47:0] A1 = 48'h08002B112233;

    vec_t vecs[11];
    vec_t v;

    initial begin
        //                  da               npre errpos  en      pr    am    acc   idx   bc    mc
        vecs[0]  = '{A1,              7, -1, 14'h0008, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[1]  = '{48'hFFFFFFFFFFFF, 7, -1, 14'h0008, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1};
        vecs[2]  = '{48'h09002B000001, 7, -1, 14'h0008, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1};
        vecs[3]  = '{48'h09002B000001, 7, -1, 14'h0008, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1};
        vecs[4]  = '{A1,              7,  2, 14'h0008, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[5]  = '{48'h021122334455, 7, -1, 14'h0008, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{A1,              0, -1, 14'h0008, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[7]  = '{A1,              7, -1, 14'h0000, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[8]  = '{48'hFFFFFFFFFFFF, 3,  5, 14'h0008, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1};
        vecs[9]  = '{A1,              7, -1, 14'h000A, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[10] = '{48'h08002B112234, 7, -1, 14'h0008, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0};

        rst = 1'b1; rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
        promisc = 1'b0; allmulti = 1'b0; tbl_we = 1'b0; tbl_idx = '0;
        tbl_byte = '0; tbl_data = '0; tbl_en = '0;
        repeat (3) @(negedge clk);

        chk("reset vld", 32'(vld), 32'd0);
        chk("reset accept", 32'(accept), 32'd0);
        chk("reset match_idx", 32'(match_idx), 32'hF);
        chk("reset bcast", 32'(bcast), 32'd0);
        chk("reset mcast", 32'(mcast), 32'd0);
        chk("reset abort", 32'(abort), 32'd0);
        chk("reset tbl_busy", 32'(tbl_busy), 32'd0);
        rst = 1'b0;

        load(3, A1);
        load(1, A1);

        for (int i = 0; i < 11; i++) send(vecs[i], $sformatf("vec%0d", i));

        // Abort after 3 destination bytes, then a normal frame
        tbl_en = 14'h0008;
        preamble(7);
        chk("busy in dest", 32'(tbl_busy), 32'd1);
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h2B, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("abort pulse", 32'(abort), 32'd1);
        chk("abort no vld", 32'(vld), 32'd0);
        chk("abort busy clear", 32'(tbl_busy), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("abort one cycle", 32'(abort), 32'd0);
        send(vecs[0], "post-abort");

        // Table write during DEST is dropped; tbl_en change mid-frame ignored
        tbl_en = 14'h0008;
        preamble(7);
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        chk("busy before wr", 32'(tbl_busy), 32'd1);
        tbl_we = 1'b1; tbl_idx = 4'd3; tbl_byte = 3'd0; tbl_data = 8'h00;
        tbl_en = 14'h0000;
        drive(1'b1, 8'h2B, 1'b0);
        tbl_we = 1'b0;
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        chk("en-change vld", 32'(vld), 32'd1);
        chk("en-change accept", 32'(accept), 32'd1);
        chk("en-change match_idx", 32'(match_idx), 32'd3);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        send(vecs[0], "busy-drop");

        // Idle write does take effect: entry 3 last byte becomes 34
        wr(3, 5, 8'h34);
        v = vecs[10]; v.acc = 1'b1; v.idx = 4'd3;
        send(v, "idle-wr");
        wr(3, 5, 8'h33);

        // Reset mid-frame: no vld, no abort, FSM back to idle
        tbl_en = 14'h0008;
        preamble(7);
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h2B, 1'b0);
        chk("rst vld", 32'(vld), 32'd0);
        chk("rst abort", 32'(abort), 32'd0);
        chk("rst busy", 32'(tbl_busy), 32'd0);
        chk("rst match_idx", 32'(match_idx), 32'hF);
        rst = 1'b0;
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("rst no late abort", 32'(abort), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        send(vecs[0], "post-rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
